// File: rtl/alu_pkg.sv
// Shared constants for the ALU command issue stage: operand width, opcodes and
// the issue FSM state encoding.
package alu_pkg;

   localparam int DATA_W = 20;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRIVE = 2'b01,
      ST_RESP  = 2'b10
   } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, async active-low reset.
// Head entry is visible on dout combinationally whenever empty is low.
module alu_cmd_fifo #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/alu_cmd_issue.sv
// Issue stage for the combinational ALU: queues commands, holds operands for ALU_WAIT
// cycles, captures the result and returns it over valid/ready. Optional: DIV_ZERO_CHECK_EN.
module alu_cmd_issue #(
   parameter int DATA_W   = alu_pkg::DATA_W,
   parameter int DEPTH    = 4,
   parameter int ALU_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [2:0]        cmd_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_c,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [2:0]        rsp_sel,
   output logic              rsp_err,
   output logic              busy
);

   import alu_pkg::*;

   localparam int CMD_W = 2*DATA_W + 3;
   localparam int WCW   = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

   state_t            state;
   state_t            state_nxt;
   logic [WCW-1:0]    wait_cnt;
   logic [WCW-1:0]    wait_cnt_nxt;
   logic              load_cmd;
   logic              capture;
   logic [CMD_W-1:0]  fifo_din;
   logic [CMD_W-1:0]  fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] res_data;
   logic              res_err;

   assign fifo_din  = {cmd_a, cmd_b, cmd_sel};
   assign cmd_ready = !fifo_full;
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   alu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid && cmd_ready),
      .din   (fifo_din),
      .pop   (load_cmd),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state logic: one command in flight, popped only from IDLE.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      load_cmd     = 1'b0;
      capture      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               load_cmd     = 1'b1;
               wait_cnt_nxt = WCW'(ALU_WAIT - 1);
               state_nxt    = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (wait_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               wait_cnt_nxt = wait_cnt - WCW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The ALU output is meaningless for NOP (and, when checked, for divide by zero),
   // so those cases substitute a fixed value and flag an error instead.
   always_comb begin
      res_data = alu_c;
      res_err  = 1'b0;
      if (alu_sel == OP_NOP) begin
         res_data = '0;
         res_err  = 1'b1;
      end
`ifdef DIV_ZERO_CHECK_EN
      else if ((alu_sel == OP_DIV) && (alu_b == '0)) begin
         res_data = '1;
         res_err  = 1'b1;
      end
`else
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_sel  <= '0;
         rsp_data <= '0;
         rsp_sel  <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (load_cmd) begin
            alu_a   <= fifo_dout[CMD_W-1 -: DATA_W];
            alu_b   <= fifo_dout[DATA_W+2 -: DATA_W];
            alu_sel <= fifo_dout[2:0];
         end
         if (capture) begin
            rsp_data <= res_data;
            rsp_sel  <= alu_sel;
            rsp_err  <= res_err;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: behavioural ALU, scoreboard of expected
// responses checked every cycle, plus directed literal checks.
module tb_alu_cmd_issue;

   localparam int DW = 20;

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    sel;
      logic          err;
   } rsp_t;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] cmd_a;
   logic [DW-1:0] cmd_b;
   logic [2:0]    cmd_sel;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_sel;
   logic [DW-1:0] alu_c;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [2:0]    rsp_sel;
   logic          rsp_err;
   logic          busy;

   int   checkCount = 0;
   int   passCount  = 0;
   int   rspCount   = 0;
   rsp_t sb[$];

   alu_cmd_issue #(
      .DATA_W   (DW),
      .DEPTH    (4),
      .ALU_WAIT (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_sel   (cmd_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_c     (alu_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_sel   (rsp_sel),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in combinational ALU; divide by zero returns a recognisable junk value.
   function automatic logic [DW-1:0] aluFn(logic [DW-1:0] a, logic [DW-1:0] b, logic [2:0] sel);
      logic [2*DW-1:0] p;
      case (sel)
         3'b001:  return a + b;
         3'b010:  return a - b;
         3'b011:  begin p = a * b; return p[DW-1:0]; end
         3'b100:  return (b == 0) ? 20'h12345 : a / b;
         3'b101:  return a & b;
         3'b110:  return a | b;
         3'b111:  return a ^ b;
         default: return 20'hABCDE;
      endcase
   endfunction

   assign alu_c = aluFn(alu_a, alu_b, alu_sel);

   function automatic rsp_t expRsp(logic [DW-1:0] a, logic [DW-1:0] b, logic [2:0] sel);
      rsp_t r;
      r.sel  = sel;
      r.err  = 1'b0;
      r.data = aluFn(a, b, sel);
      if (sel == 3'b000) begin
         r.data = '0;
         r.err  = 1'b1;
      end
`ifdef DIV_ZERO_CHECK_EN
      else if (sel == 3'b100 && b == 0) begin
         r.data = 20'hFFFFF;
         r.err  = 1'b1;
      end
`endif
      return r;
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic failNow(string name);
      checkCount++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   // Per-cycle comparison against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               failNow("unexpected_rsp");
            end else begin
               checkOutput("rsp_data", {12'd0, rsp_data}, {12'd0, sb[0].data});
               checkOutput("rsp_sel",  {29'd0, rsp_sel},  {29'd0, sb[0].sel});
               checkOutput("rsp_err",  {31'd0, rsp_err},  {31'd0, sb[0].err});
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  rspCount++;
               end
            end
         end
      end
   end

   // Called and returns aligned to posedge+1; pushes one command.
   task automatic applyStimulus(logic [DW-1:0] a, logic [DW-1:0] b, logic [2:0] sel);
      logic acc;
      logic done;
      done      = 1'b0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         if (acc) done = 1'b1;
      end
      if (done) sb.push_back(expRsp(a, b, sel));
      else failNow("push_timeout");
   endtask

   task automatic stepCycles(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (sb.size() != 0 && i < 200) begin
         stepCycles(1);
         i++;
      end
      if (sb.size() != 0) failNow("drain_timeout");
   endtask

   // Single command with rsp_ready=1; literal check of the returned response.
   task automatic runOne(string name, logic [DW-1:0] a, logic [DW-1:0] b, logic [2:0] sel,
                         logic [DW-1:0] expData, logic expErr);
      int cyc;
      applyStimulus(a, b, sel);
      cmd_valid = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (!rsp_valid && cyc < 30) begin
         cyc++;
         @(negedge clk);
      end
      if (!rsp_valid) begin
         failNow({name, "_timeout"});
      end else begin
         checkOutput({name, "_latency"}, cyc, 3);
         checkOutput({name, "_data"}, {12'd0, rsp_data}, {12'd0, expData});
         checkOutput({name, "_err"}, {31'd0, rsp_err}, {31'd0, expErr});
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      int base;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b0;
      #12;
      checkOutput("rst_alu_a", {12'd0, alu_a}, 0);
      checkOutput("rst_alu_sel", {29'd0, alu_sel}, 0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      checkOutput("rst_rsp_data", {12'd0, rsp_data}, 0);
      checkOutput("rst_busy", {31'd0, busy}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 1);

      $display("[TB] basic operations");
      rsp_ready = 1'b1;
      runOne("t1_add", 20'd5, 20'd3, 3'b001, 20'd8, 1'b0);
      runOne("t2_sub", 20'd2, 20'd5, 3'b010, 20'hFFFFD, 1'b0);
      runOne("t2_mul", 20'h80000, 20'd2, 3'b011, 20'h00000, 1'b0);
      runOne("t2_xor", 20'hF0F0F, 20'h0FF00, 3'b111, 20'hFF00F, 1'b0);
      runOne("t2_div", 20'd100, 20'd7, 3'b100, 20'd14, 1'b0);
`ifdef DIV_ZERO_CHECK_EN
      runOne("t4_divz", 20'd9, 20'd0, 3'b100, 20'hFFFFF, 1'b1);
`else
      runOne("t4_divz", 20'd9, 20'd0, 3'b100, 20'h12345, 1'b0);
`endif
      runOne("t5_nop", 20'd7, 20'd7, 3'b000, 20'd0, 1'b1);

      $display("[TB] back-pressure and FIFO full");
      rsp_ready = 1'b0;
      base = rspCount;
      applyStimulus(20'd1, 20'd1, 3'b001);
      applyStimulus(20'd10, 20'd3, 3'b010);
      applyStimulus(20'd6, 20'd7, 3'b011);
      applyStimulus(20'hF0F0F, 20'h0FFFF, 3'b101);
      applyStimulus(20'h12, 20'h21, 3'b110);
      cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("t3_full", {31'd0, cmd_ready}, 0);
      stepCycles(6);
      checkOutput("t3_held_valid", {31'd0, rsp_valid}, 1);
      checkOutput("t3_held_data", {12'd0, rsp_data}, 2);
      rsp_ready = 1'b1;
      drain();
      checkOutput("t3_count", rspCount - base, 5);
      checkOutput("t3_ready_again", {31'd0, cmd_ready}, 1);

      $display("[TB] reset mid-command");
      rsp_ready = 1'b0;
      applyStimulus(20'd40, 20'd2, 3'b001);
      applyStimulus(20'd11, 20'd1, 3'b001);
      applyStimulus(20'd12, 20'd1, 3'b001);
      applyStimulus(20'd13, 20'd1, 3'b001);
      cmd_valid = 1'b0;
      stepCycles(3);
      rsp_ready = 1'b1;
      stepCycles(2);
      checkOutput("t6_drive_alu_a", {12'd0, alu_a}, 11);
      rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("t6_rst_alu_a", {12'd0, alu_a}, 0);
      checkOutput("t6_rst_alu_b", {12'd0, alu_b}, 0);
      checkOutput("t6_rst_rsp_data", {12'd0, rsp_data}, 0);
      checkOutput("t6_rst_rsp_valid", {31'd0, rsp_valid}, 0);
      checkOutput("t6_rst_busy", {31'd0, busy}, 0);
      stepCycles(2);
      rst_n = 1'b1;
      stepCycles(6);
      checkOutput("t6_post_valid", {31'd0, rsp_valid}, 0);
      checkOutput("t6_post_busy", {31'd0, busy}, 0);

      runOne("t6_after", 20'd20, 20'd22, 3'b110, 20'd22, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
